// File: rtl/ysyx_25020047_lsu.sv
// Multi-cycle load/store unit: execute request -> valid/ready memory bus -> extracted load data to writeback.
// Optional YSYX_25020047_LSU_MISALIGN_CHK_EN: misaligned half/word accesses return err=1 with no bus activity.
module ysyx_25020047_lsu #(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] memdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic       wen;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } req_t;

  state_t      state;
  req_t        rq;
  logic [31:0] cnt;

  logic [3:0]  a_wmask;
  logic [31:0] a_wdata;
  logic        a_mis;

  always_comb begin
    a_wmask = 4'b1111;
    a_wdata = req_wdata;
    a_mis   = 1'b0;
    case (req_size)
      2'd0: begin
        a_wmask = 4'b0001 << req_addr[1:0];
        a_wdata = req_wdata << {req_addr[1:0], 3'b000};
      end
      2'd1: begin
        a_wmask = 4'b0011 << req_addr[1:0];
        a_wdata = req_wdata << {req_addr[1:0], 3'b000};
      end
      default: ;
    endcase
`ifdef YSYX_25020047_LSU_MISALIGN_CHK_EN
    a_mis = ((req_size == 2'd1) && req_addr[0]) ||
            (req_size[1] && (req_addr[1:0] != 2'b00));
`endif
  end

  // Halves pick their lane from addr[1] only, so a misaligned half reads the aligned half.
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  assign ld_b = 8'(mem_rdata >> {rq.off, 3'b000});
  assign ld_h = 16'(mem_rdata >> {rq.off[1], 4'b0000});

  always_comb begin
    case (rq.size)
      2'd0:    ld_data = {{24{rq.sgn & ld_b[7]}}, ld_b};
      2'd1:    ld_data = {{16{rq.sgn & ld_h[15]}}, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rq         <= '0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wmask  <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      memdata    <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          rq        <= '{wen: req_wen, size: req_size, sgn: req_signed, off: req_addr[1:0]};
          req_ready <= 1'b0;
          if (a_mis) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            memdata    <= '0;
            err        <= 1'b1;
          end else begin
            state     <= REQ;
            mem_valid <= 1'b1;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wen   <= req_wen;
            mem_wmask <= a_wmask;
            mem_wdata <= a_wdata;
          end
        end
        REQ: if (mem_ready) begin
          mem_valid <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // rvalid is checked first so it wins over a coinciding timeout
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            memdata    <= rq.wen ? 32'd0 : ld_data;
            err        <= 1'b0;
          end else if ((TIMEOUT_CYC != 0) && (cnt == 32'(TIMEOUT_CYC - 1))) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            memdata    <= '0;
            err        <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Randomized self-checking bench for ysyx_25020047_lsu against a byte-lane arithmetic model.
module tb_ysyx_25020047_lsu;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        resp_valid, resp_ready, err;
  logic [31:0] memdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ysyx_25020047_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .memdata(memdata), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef YSYX_25020047_LSU_MISALIGN_CHK_EN
    return (size == 2'd1 && (addr % 2) != 0) || (size >= 2'd2 && (addr % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    int unsigned v;
    case (size)
      2'd0: begin
        v = (rdata >> (8 * (addr % 4))) & 32'hFF;
        if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_mask(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return (32'd1 << (addr % 4)) & 32'hF;
      2'd1:    return (32'd3 << (addr % 4)) & 32'hF;
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] wdata);
    if (size >= 2'd2) return wdata;
    return wdata << (8 * (addr % 4));
  endfunction

  // mr_dly: cycles mem_ready stays low; rv_dly: WAIT cycle carrying rvalid (>=TO: never);
  // rr_dly: cycles resp_ready stays low.
  task automatic txn(input logic wen, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                     input int mr_dly, input int rv_dly, input int rr_dly);
    logic        mis, exp_e, got_rv;
    logic [31:0] exp_d;
    mis = model_mis(size, addr);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_wen = wen; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock); @(negedge clock);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_wen = 1'($urandom);
    if (mis) begin
      chk("mis_no_bus", mem_valid, 0);
      exp_e = 1; exp_d = 0;
    end else begin
      for (int i = 0; i <= mr_dly; i++) begin
        chk("mem_valid", mem_valid, 1);
        chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("mem_wen", mem_wen, wen);
        if (wen) begin
          chk("mem_wmask", mem_wmask, model_mask(size, addr));
          chk("mem_wdata", mem_wdata, model_wdata(size, addr, wdata));
        end
        chk("req_ready_busy", req_ready, 0);
        chk("resp_early", resp_valid, 0);
        mem_ready = (i == mr_dly); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        @(posedge clock); @(negedge clock);
        mem_ready = 0; mem_rvalid = 0;
      end
      exp_e = (rv_dly >= TO);
      exp_d = (wen || exp_e) ? 32'd0 : model_load(size, sgn, addr, rdata);
      for (int k = 0; k < TO; k++) begin
        chk("mem_valid_wait", mem_valid, 0);
        mem_rvalid = (k == rv_dly);
        mem_rdata  = (k == rv_dly) ? rdata : $urandom;
        @(posedge clock); @(negedge clock);
        mem_rvalid = 0;
        got_rv = resp_valid;
        chk("resp_valid_wait", resp_valid, (k == rv_dly) || (k == TO - 1));
        if (got_rv) break;
      end
    end
    for (int j = 0; j <= rr_dly; j++) begin
      chk("resp_valid", resp_valid, 1);
      chk("memdata", memdata, exp_d);
      chk("err", err, exp_e);
      chk("req_ready_resp", req_ready, 0);
      resp_ready = (j == rr_dly); req_valid = (j == rr_dly); mem_rvalid = 1'($urandom);
      @(posedge clock); @(negedge clock);
      resp_ready = 0; req_valid = 0; mem_rvalid = 0;
    end
    chk("resp_done", resp_valid, 0);
    chk("no_bypass", mem_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; req_valid = 0; req_wen = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; resp_ready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_memdata", memdata, 0);
    chk("rst_err", err, 0);

    txn(0, 2'd0, 1, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    txn(0, 2'd1, 0, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 0, 0);
    txn(0, 2'd1, 1, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 1, 1);
    txn(1, 2'd0, 0, 32'h8000_0001, 32'h0000_00AB, 32'h1234_5678, 0, 0, 0);
    txn(0, 2'd2, 0, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 5, 0, 3);
    txn(0, 2'd2, 0, 32'h8000_0020, 32'h0, 32'h1111_2222, 0, TO, 0);
    txn(0, 2'd2, 0, 32'h8000_0024, 32'h0, 32'h3333_4444, 0, TO - 1, 0);
    txn(0, 2'd2, 0, 32'h8000_0002, 32'h0, 32'h5555_6666, 0, 0, 0);
    txn(0, 2'd3, 1, 32'h8000_0004, 32'h0, 32'h8765_4321, 1, 2, 0);
    txn(1, 2'd1, 0, 32'h8000_0003, 32'h0000_BEEF, 32'h0, 0, 1, 1);

    // reset in WAIT drops the transaction
    req_valid = 1; req_wen = 0; req_size = 2'd2; req_addr = 32'h8000_0040;
    @(posedge clock); @(negedge clock);
    req_valid = 0; mem_ready = 1;
    @(posedge clock); @(negedge clock);
    mem_ready = 0; reset = 1;
    @(posedge clock); @(negedge clock);
    reset = 0;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_mem_valid", mem_valid, 0);
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1; mem_rdata = $urandom;
      @(posedge clock); @(negedge clock);
      mem_rvalid = 0;
      chk("midrst_no_resp", resp_valid, 0);
    end

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
      txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, TO), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
